// File: rtl/wb_master_bridge.sv
// Wishbone master bridge: turns single CPU load/store requests into
// Wishbone classic cycles with retry, timeout, flush and stall handling.
// Ports: clk/rst; stall_ctrl, flush_i from pipeline control;
//   cpu_* request/response side, stall_req back to control;
//   wb_* master side (all wb_* outputs registered).
module wb_master_bridge #(
   parameter int DW        = 32,
   parameter int AW        = 32,
   parameter int STALLW    = 6,
   parameter int RETRY_MAX = 3,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [STALLW-1:0] stall_ctrl,
   input  logic              flush_i,
   input  logic              cpu_ce_i,
   input  logic [AW-1:0]     cpu_addr_i,
   input  logic [DW-1:0]     cpu_data_i,
   input  logic              cpu_we_i,
   input  logic [DW/8-1:0]   cpu_sel_i,
   output logic [DW-1:0]     cpu_data_o,
   output logic              cpu_err_o,
   output logic              stall_req,
   input  logic [DW-1:0]     wb_data_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i,
   input  logic              wb_rty_i,
   output logic [AW-1:0]     wb_addr_o,
   output logic [DW-1:0]     wb_data_o,
   output logic              wb_we_o,
   output logic [DW/8-1:0]   wb_sel_o,
   output logic              wb_stb_o,
   output logic              wb_cyc_o
);

   localparam int RW = $clog2(RETRY_MAX) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [RW-1:0] RMAX  = RW'(RETRY_MAX);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_BACKOFF,
      S_WAIT
   } state_t;

   state_t        state;
   logic [DW-1:0] data_buf;
   logic          err_buf;
   logic [RW-1:0] retry_cnt;
   logic [TW-1:0] timer;

   logic busy;
   logic accept;
   logic t_ack;
   logic t_err;
   logic t_fl;
   logic rty_hit;
   logic t_rty;
   logic t_rty_err;
   logic t_to;
   logic t_fail;
   logic t_any;

   assign busy   = (state == S_BUSY);
   assign accept = (state == S_IDLE) && cpu_ce_i && !flush_i;

   // Termination decode, priority ack > err > flush > rty > timeout
   assign t_ack     = busy && wb_ack_i;
   assign t_err     = busy && !wb_ack_i && wb_err_i;
   assign t_fl      = busy && !wb_ack_i && !wb_err_i
                      && flush_i;
   assign rty_hit   = busy && !wb_ack_i && !wb_err_i
                      && !flush_i && wb_rty_i;
   assign t_rty     = rty_hit && (retry_cnt != RMAX);
   assign t_rty_err = rty_hit && (retry_cnt == RMAX);
   assign t_to      = busy && !wb_ack_i && !wb_err_i
                      && !flush_i && !wb_rty_i
                      && (timer == TLAST);
   assign t_fail    = t_err || t_rty_err || t_to;
   assign t_any     = t_ack || t_err || t_fl
                      || rty_hit || t_to;

   // Response path is combinational so the ack cycle
   // itself carries the read data back to the CPU.
   assign stall_req = !rst && (accept
                      || (busy && !t_any)
                      || (state == S_BACKOFF));

   assign cpu_err_o = !rst && (t_fail
                      || ((state == S_WAIT) && err_buf));

   always_comb begin
      cpu_data_o = '0;
      if (!rst) begin
         if (t_ack && !wb_we_o)
            cpu_data_o = wb_data_i;
         else if (state == S_WAIT)
            cpu_data_o = data_buf;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         wb_addr_o <= '0;
         wb_data_o <= '0;
         wb_we_o   <= 1'b0;
         wb_sel_o  <= '0;
         wb_stb_o  <= 1'b0;
         wb_cyc_o  <= 1'b0;
         data_buf  <= '0;
         err_buf   <= 1'b0;
         retry_cnt <= '0;
         timer     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  wb_addr_o <= cpu_addr_i;
                  wb_data_o <= cpu_data_i;
                  wb_we_o   <= cpu_we_i;
                  wb_sel_o  <= cpu_sel_i;
                  wb_stb_o  <= 1'b1;
                  wb_cyc_o  <= 1'b1;
                  retry_cnt <= '0;
                  timer     <= '0;
                  state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (t_ack || t_fail || t_fl) begin
                  wb_addr_o <= '0;
                  wb_data_o <= '0;
                  wb_we_o   <= 1'b0;
                  wb_sel_o  <= '0;
                  wb_stb_o  <= 1'b0;
                  wb_cyc_o  <= 1'b0;
                  data_buf  <= (t_ack && !wb_we_o)
                               ? wb_data_i : '0;
                  err_buf   <= t_fail;
                  // A flush never parks in WAIT
                  state     <= (!t_fl && (|stall_ctrl))
                               ? S_WAIT : S_IDLE;
               end else if (t_rty) begin
                  // Keep the request latched for the reissue
                  wb_stb_o  <= 1'b0;
                  wb_cyc_o  <= 1'b0;
                  retry_cnt <= retry_cnt + 1'b1;
                  state     <= S_BACKOFF;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_BACKOFF: begin
               if (flush_i) begin
                  wb_addr_o <= '0;
                  wb_data_o <= '0;
                  wb_we_o   <= 1'b0;
                  wb_sel_o  <= '0;
                  state     <= S_IDLE;
               end else begin
                  wb_stb_o <= 1'b1;
                  wb_cyc_o <= 1'b1;
                  timer    <= '0;
                  state    <= S_BUSY;
               end
            end
            S_WAIT: begin
               if (stall_ctrl == '0)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: vector table of
// transactions plus hand-written reset/flush corner sequences.
module tb_wb_master_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall_ctrl;
   logic        flush_i;
   logic        cpu_ce_i;
   logic [31:0] cpu_addr_i;
   logic [31:0] cpu_data_i;
   logic        cpu_we_i;
   logic [3:0]  cpu_sel_i;
   logic [31:0] cpu_data_o;
   logic        cpu_err_o;
   logic        stall_req;
   logic [31:0] wb_data_i;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        wb_rty_i;
   logic [31:0] wb_addr_o;
   logic [31:0] wb_data_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;

   always #5 clk = ~clk;

   wb_master_bridge #(
      .DW(32), .AW(32), .STALLW(6),
      .RETRY_MAX(3), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .stall_ctrl(stall_ctrl), .flush_i(flush_i),
      .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i),
      .cpu_data_i(cpu_data_i), .cpu_we_i(cpu_we_i),
      .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
      .cpu_err_o(cpu_err_o), .stall_req(stall_req),
      .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
      .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
      .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
      .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          n_rty;
      int          lat;
      logic        ack;
      logic        err;
      logic        rty;
      logic        fl;
      logic [31:0] rdata;
      int          n_stall;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h",
                  nm, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_term();
      wb_ack_i  = 1'b0;
      wb_err_i  = 1'b0;
      wb_rty_i  = 1'b0;
      flush_i   = 1'b0;
      wb_data_i = '0;
   endtask

   function automatic vec_t mk(
      input string nm, input logic we,
      input logic [31:0] addr, input logic [31:0] wd,
      input logic [3:0] sel, input int n_rty,
      input int lat, input logic [3:0] term,
      input logic [31:0] rd, input int n_stall,
      input logic [31:0] ed, input logic ee);
      vec_t v;
      v.name = nm; v.we = we; v.addr = addr;
      v.wdata = wd; v.sel = sel; v.n_rty = n_rty;
      v.lat = lat;
      v.ack = term[3]; v.err = term[2];
      v.rty = term[1]; v.fl = term[0];
      v.rdata = rd; v.n_stall = n_stall;
      v.exp_data = ed; v.exp_err = ee;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   gaps;
      int   lat;
      gaps = 0;
      e.d = '0;
      e.e = 1'b0;
      cpu_ce_i   = 1'b1;
      cpu_addr_i = v.addr;
      cpu_data_i = v.wdata;
      cpu_we_i   = v.we;
      cpu_sel_i  = v.sel;
      sb.push_back('{v.exp_data, v.exp_err});
      @(negedge clk);
      chk({v.name, ".stall_acc"}, 64'(stall_req), 64'(1));
      next_cyc();
      cpu_ce_i   = 1'b0;
      cpu_addr_i = '0;
      cpu_data_i = '0;
      cpu_we_i   = 1'b0;
      cpu_sel_i  = '0;
      for (int a = 0; a <= v.n_rty; a++) begin
         lat = (a < v.n_rty) ? 1 : v.lat;
         for (int c = 1; c <= lat; c++) begin
            if (c == lat) begin
               if (a < v.n_rty) begin
                  wb_rty_i = 1'b1;
               end else begin
                  wb_ack_i   = v.ack;
                  wb_err_i   = v.err;
                  wb_rty_i   = v.rty;
                  flush_i    = v.fl;
                  wb_data_i  = v.rdata;
                  stall_ctrl = (v.n_stall > 0)
                               ? 6'b000011 : 6'b0;
               end
            end
            @(negedge clk);
            chk({v.name, ".stbcyc"},
                64'({wb_stb_o, wb_cyc_o}), 64'(2'b11));
            chk({v.name, ".addr"}, 64'(wb_addr_o),
                64'(v.addr));
            if (a == 0 && c == 1) begin
               chk({v.name, ".wdata"}, 64'(wb_data_o),
                   64'(v.wdata));
               chk({v.name, ".we"}, 64'(wb_we_o),
                   64'(v.we));
               chk({v.name, ".sel"}, 64'(wb_sel_o),
                   64'(v.sel));
            end
            if (c < lat)
               chk({v.name, ".stall_busy"},
                   64'(stall_req), 64'(1));
            if (c == lat && a == v.n_rty) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL %s.sb: queue empty", v.name);
               end else begin
                  e = sb.pop_front();
                  chk({v.name, ".data"}, 64'(cpu_data_o),
                      64'(e.d));
                  chk({v.name, ".err"}, 64'(cpu_err_o),
                      64'(e.e));
                  chk({v.name, ".stall_term"},
                      64'(stall_req), 64'(0));
               end
            end
            next_cyc();
            clr_term();
         end
         if (a < v.n_rty) begin
            @(negedge clk);
            chk({v.name, ".bo_stb"}, 64'(wb_stb_o),
                64'(0));
            chk({v.name, ".bo_stall"}, 64'(stall_req),
                64'(1));
            if (!wb_stb_o)
               gaps++;
            next_cyc();
         end
      end
      for (int s = 1; s <= v.n_stall; s++) begin
         if (s == v.n_stall)
            stall_ctrl = '0;
         @(negedge clk);
         chk({v.name, ".w_data"}, 64'(cpu_data_o),
             64'(e.d));
         chk({v.name, ".w_err"}, 64'(cpu_err_o),
             64'(e.e));
         chk({v.name, ".w_stall"}, 64'(stall_req),
             64'(0));
         chk({v.name, ".w_stb"}, 64'(wb_stb_o), 64'(0));
         next_cyc();
      end
      stall_ctrl = '0;
      @(negedge clk);
      chk({v.name, ".i_data"}, 64'(cpu_data_o), 64'(0));
      chk({v.name, ".i_err"}, 64'(cpu_err_o), 64'(0));
      chk({v.name, ".i_bus"},
          64'({wb_stb_o, wb_cyc_o, wb_we_o, wb_sel_o}),
          64'(0));
      chk({v.name, ".i_addr"}, 64'(wb_addr_o), 64'(0));
      chk({v.name, ".gaps"}, 64'(gaps), 64'(v.n_rty));
      next_cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = mk("rd_ack3", 0, 32'h100, 0, 4'hF,
                    0, 3, 4'b1000, 32'hDEADBEEF, 0,
                    32'hDEADBEEF, 0);
      vecs[1]  = mk("wr_ack", 1, 32'h200, 32'hCAFEF00D,
                    4'b0011, 0, 1, 4'b1000, 32'h55555555,
                    0, 32'h0, 0);
      vecs[2]  = mk("rd_stall", 0, 32'h300, 0, 4'hF,
                    0, 2, 4'b1000, 32'h12345678, 2,
                    32'h12345678, 0);
      vecs[3]  = mk("rty3_ack", 0, 32'h400, 0, 4'hF,
                    3, 1, 4'b1000, 32'hA5A5A5A5, 0,
                    32'hA5A5A5A5, 0);
      vecs[4]  = mk("rty4_err", 0, 32'h500, 0, 4'hF,
                    3, 1, 4'b0010, 32'h11111111, 0,
                    32'h0, 1);
      vecs[5]  = mk("timeout", 0, 32'h600, 0, 4'hF,
                    0, 8, 4'b0000, 32'h22222222, 0,
                    32'h0, 1);
      vecs[6]  = mk("flush", 0, 32'h700, 0, 4'hF,
                    0, 2, 4'b0001, 32'h33333333, 0,
                    32'h0, 0);
      vecs[7]  = mk("ack_err_rty", 0, 32'h800, 0, 4'hF,
                    0, 1, 4'b1110, 32'h0BADF00D, 0,
                    32'h0BADF00D, 0);
      vecs[8]  = mk("err_stall", 0, 32'h900, 0, 4'hF,
                    0, 1, 4'b0100, 32'h44444444, 2,
                    32'h0, 1);
      vecs[9]  = mk("wr_rty1", 1, 32'hA00, 32'h600DCAFE,
                    4'b1100, 1, 4, 4'b1000, 32'h0, 0,
                    32'h0, 0);
      vecs[10] = mk("rd_lat7", 0, 32'hB00, 0, 4'hF,
                    0, 7, 4'b1000, 32'h77777777, 0,
                    32'h77777777, 0);

      rst        = 1'b1;
      stall_ctrl = '0;
      cpu_ce_i   = 1'b1;
      cpu_addr_i = 32'h5A5A;
      cpu_data_i = '0;
      cpu_we_i   = 1'b0;
      cpu_sel_i  = 4'hF;
      clr_term();
      wb_ack_i   = 1'b1;
      wb_data_i  = 32'hFFFFFFFF;
      #22;
      chk("rst.stall", 64'(stall_req), 64'(0));
      chk("rst.data", 64'(cpu_data_o), 64'(0));
      chk("rst.err", 64'(cpu_err_o), 64'(0));
      chk("rst.bus",
          64'({wb_stb_o, wb_cyc_o, wb_we_o, wb_sel_o}),
          64'(0));
      chk("rst.addr", 64'(wb_addr_o), 64'(0));
      @(negedge clk);
      rst      = 1'b0;
      cpu_ce_i = 1'b0;
      clr_term();
      next_cyc();

      foreach (vecs[i])
         run_vec(vecs[i]);

      // Flush in IDLE blocks acceptance
      cpu_ce_i   = 1'b1;
      flush_i    = 1'b1;
      cpu_addr_i = 32'hD00;
      @(negedge clk);
      chk("idle_fl.stall", 64'(stall_req), 64'(0));
      next_cyc();
      cpu_ce_i = 1'b0;
      flush_i  = 1'b0;
      @(negedge clk);
      chk("idle_fl.stb", 64'(wb_stb_o), 64'(0));
      next_cyc();

      // Flush during BACKOFF returns to IDLE
      cpu_ce_i   = 1'b1;
      cpu_addr_i = 32'hC00;
      next_cyc();
      cpu_ce_i = 1'b0;
      wb_rty_i = 1'b1;
      @(negedge clk);
      chk("bo_fl.busy", 64'(wb_stb_o), 64'(1));
      next_cyc();
      wb_rty_i = 1'b0;
      flush_i  = 1'b1;
      @(negedge clk);
      chk("bo_fl.bo_stb", 64'(wb_stb_o), 64'(0));
      chk("bo_fl.bo_stall", 64'(stall_req), 64'(1));
      next_cyc();
      flush_i = 1'b0;
      @(negedge clk);
      chk("bo_fl.idle_stb", 64'(wb_stb_o), 64'(0));
      chk("bo_fl.err", 64'(cpu_err_o), 64'(0));
      chk("bo_fl.stall", 64'(stall_req), 64'(0));
      next_cyc();

      // Async reset mid-BUSY drops the bus before any edge
      cpu_ce_i   = 1'b1;
      cpu_addr_i = 32'hE00;
      next_cyc();
      cpu_ce_i = 1'b0;
      @(negedge clk);
      chk("arst.busy", 64'(wb_cyc_o), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("arst.cyc", 64'(wb_cyc_o), 64'(0));
      chk("arst.stb", 64'(wb_stb_o), 64'(0));
      chk("arst.stall", 64'(stall_req), 64'(0));
      chk("arst.addr", 64'(wb_addr_o), 64'(0));
      #1;
      rst = 1'b0;
      next_cyc();
      @(negedge clk);
      chk("arst.idle", 64'(wb_cyc_o), 64'(0));
      next_cyc();
      run_vec(vecs[0]);

      chk("sb.empty", 64'(sb.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter AW, default 32: address width in bits.
REQ-003 SHALL have parameter STALLW, default 6: width of stall_ctrl.
REQ-004 SHALL have parameter RETRY_MAX, default 3: number of wb_rty_i retries allowed (1..15).
REQ-005 SHALL have parameter TIMEOUT, default 255: number of BUSY cycles without ack/err/rty before abort (1..65535).
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 SHALL have these ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- stall_ctrl  in  STALLW  pipeline stall vector; nonzero = stalled
- flush_i  in  1  pipeline flush
- cpu_ce_i  in  1  CPU request
- cpu_addr_i  in  AW  request address
- cpu_data_i  in  DW  write data
- cpu_we_i  in  1  1 = write
- cpu_sel_i  in  DW/8  byte lanes
- cpu_data_o  out  DW  read data to CPU
- cpu_err_o  out  1  bus error indication to CPU
- stall_req  out  1  stall request to control
- wb_data_i  in  DW  slave read data
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  slave termination
- wb_addr_o  out  AW; wb_data_o  out  DW; wb_we_o  out  1; wb_sel_o  out  DW/8; wb_stb_o, wb_cyc_o  out  1 each; all registered

Function
REQ-008 SHALL implement states IDLE, BUSY, BACKOFF and WAIT; the encoding is free.
REQ-009 In IDLE, when cpu_ce_i=1 and flush_i=0, SHALL latch addr/data/we/sel onto the wb_* outputs, assert stb/cyc next edge, clear retry_cnt and timer, and go to BUSY.
REQ-010 stall_req SHALL be combinational: 1 in IDLE with an accepted request, 1 in BUSY with no termination this cycle, 1 in BACKOFF, 0 otherwise.
REQ-011 In BUSY, termination priority SHALL be ack > err > flush_i > rty > timeout.
REQ-012 On ack in BUSY, the block SHALL:
- deassert stb/cyc and zero addr/data/we/sel next edge;
- drive cpu_data_o = wb_data_i in that same cycle for reads, 0 for writes;
- capture read data into data_buf and clear err_buf;
- go to WAIT if stall_ctrl!=0, else to IDLE.
REQ-013 On err in BUSY, SHALL behave as on ack, except that cpu_err_o=1 in that cycle, cpu_data_o=0 and err_buf=1.
REQ-014 On flush_i in BUSY without ack/err, SHALL drop the bus, clear data_buf and err_buf, go to IDLE, and drive cpu_err_o=0.
REQ-015 On rty in BUSY, SHALL drop stb/cyc next edge and enter BACKOFF with retry_cnt+1; if retry_cnt already equals RETRY_MAX, it SHALL instead be handled as err (REQ-013).
REQ-016 The timer SHALL increment each BUSY cycle with no termination; when timer reaches TIMEOUT-1 with no termination, the transaction SHALL be handled as err (REQ-013).
REQ-017 BACKOFF SHALL last exactly one cycle with stb/cyc=0, then:
- flush_i=1: go to IDLE;
- otherwise: reassert stb/cyc with the latched request, clear the timer, and go to BUSY.
REQ-018 In WAIT, SHALL drive cpu_data_o=data_buf and cpu_err_o=err_buf, and return to IDLE on the first cycle stall_ctrl==0.
REQ-019 In IDLE and BACKOFF, cpu_data_o and cpu_err_o SHALL be 0.
REQ-020 wb_stb_o SHALL always equal wb_cyc_o; wb_we_o, wb_addr_o and wb_sel_o SHALL be stable while stb=1.
REQ-021 Counter widths SHALL be $clog2 of the respective maximum plus 1, and counters SHALL never wrap.

Reset
REQ-022 On rst=1, asynchronously and regardless of clk: state=IDLE; all wb_* outputs, data_buf, err_buf, retry_cnt and timer = 0.
REQ-023 While rst=1, cpu_data_o=0, cpu_err_o=0 and stall_req=0.
REQ-024 Reset asserted mid-transaction SHALL drop stb/cyc immediately, without waiting for a clock edge.

Verification
REQ-025 Read: ce=1, addr=0x100, we=0; ack on the 3rd BUSY cycle with data 0xDEADBEEF -> stall_req=1 for 3 cycles; cpu_data_o=0xDEADBEEF in the ack cycle; stb=0 next edge.
REQ-026 Stalled completion: ack with data 0x12345678 while stall_ctrl=6'b000011 for 2 cycles -> WAIT holds cpu_data_o=0x12345678 for 2 cycles, then IDLE.
REQ-027 Retry: rty asserted 3 times then ack -> exactly 3 one-cycle stb gaps, identical addr on each attempt, normal completion; with 4 rty -> cpu_err_o=1 on the 4th.
REQ-028 Timeout: TIMEOUT=8 with no response -> stb high for 8 cycles, cpu_err_o=1 in cycle 8, stall_req=0.
REQ-029 Flush and reset: flush_i in BUSY -> IDLE, bus dropped, no cpu_err_o; async rst pulse mid-BUSY -> wb_cyc_o=0 before the next clk edge.
REQ-030 Simultaneous ack+err+rty in one cycle -> ack wins and cpu_err_o=0.
